// File: rtl/spi_reg_arbiter.sv
// Register bank shared between the SPI slave and an on-chip core port.
// Decodes SPI fast commands (sequenced clear, core lock, error clear) and builds the SPI status byte.
module spi_reg_arbiter #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_W-1:0]               spi_addr,
  input  logic [REG_W-1:0]                spi_wdata,
  input  logic                            spi_wvld,
  output logic [REG_W-1:0]                spi_rdata,
  input  logic [5:0]                      fastcmd,
  input  logic                            fastcmd_vld,
  output logic [7:0]                      status,
  input  logic                            core_req,
  input  logic                            core_we,
  input  logic [ADDR_W-1:0]               core_addr,
  input  logic [REG_W-1:0]                core_wdata,
  output logic                            core_gnt,
  output logic [REG_W-1:0]                core_rdata,
  output logic                            core_rvld,
  output logic [(2**ADDR_W)*REG_W-1:0]    reg_q
);

  localparam int NUM_REGS = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, ACK, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [REG_W-1:0]    regs_q [NUM_REGS];
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                lock_q, lock_d;
  logic                core_err_q, core_err_d;
  logic                spi_drop_q, spi_drop_d;
  logic                clr_pend_q, clr_pend_d;
  logic                ack_rd_q, ack_rd_d;
  logic [REG_W-1:0]    spi_rdata_q;
  logic [REG_W-1:0]    core_rdata_q;
  logic [7:0]          status_q;

  logic                clr_cmd;
  logic                accept;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [REG_W-1:0]    wr_data;

  assign clr_cmd = fastcmd_vld && (fastcmd == 6'h00);
  assign accept  = (state_q == IDLE) && core_req && !spi_wvld && !clr_pend_q && !clr_cmd;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_rd_d   = ack_rd_q;
    lock_d     = lock_q;
    core_err_d = core_err_q;
    spi_drop_d = spi_drop_q;
    clr_pend_d = clr_pend_q;

    case (state_q)
      IDLE: begin
        if (clr_cmd || clr_pend_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (accept) begin
          state_d  = ACK;
          ack_rd_d = !core_we;
        end
      end
      ACK: begin
        // A clear requested during the grant cycle is held in clr_pend and starts right after.
        if (clr_cmd) clr_pend_d = 1'b1;
        if (clr_cmd || clr_pend_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        clr_pend_d = 1'b0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(NUM_REGS-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fastcmd_vld) begin
      case (fastcmd)
        6'h01: lock_d = 1'b1;
        6'h02: lock_d = 1'b0;
        6'h03: begin
          core_err_d = 1'b0;
          spi_drop_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (accept && core_we && lock_q)         core_err_d = 1'b1;
    if (spi_wvld && (state_q == CLEAR))      spi_drop_d = 1'b1;
  end

  // Single bank write port: clear sequencer, then SPI, then core.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_q == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
    end else if (spi_wvld) begin
      wr_en   = 1'b1;
      wr_addr = spi_addr;
      wr_data = spi_wdata;
    end else if (accept && core_we && !lock_q) begin
      wr_en   = 1'b1;
      wr_addr = core_addr;
      wr_data = core_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ack_rd_q     <= 1'b0;
      lock_q       <= 1'b0;
      core_err_q   <= 1'b0;
      spi_drop_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
      spi_rdata_q  <= '0;
      core_rdata_q <= '0;
      status_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_rd_q    <= ack_rd_d;
      lock_q      <= lock_d;
      core_err_q  <= core_err_d;
      spi_drop_q  <= spi_drop_d;
      clr_pend_q  <= clr_pend_d;
      spi_rdata_q <= regs_q[spi_addr];
      if (accept && !core_we) core_rdata_q <= regs_q[core_addr];
      if (wr_en)              regs_q[wr_addr] <= wr_data;
      status_q <= {(state_q == CLEAR), lock_q, core_err_q, spi_drop_q, clr_pend_q, 3'b000};
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*REG_W +: REG_W] = regs_q[i];
  end

  assign spi_rdata  = spi_rdata_q;
  assign core_rdata = core_rdata_q;
  assign status     = status_q;
  assign core_gnt   = (state_q == ACK);
  assign core_rvld  = (state_q == ACK) && ack_rd_q;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed bench for spi_reg_arbiter: SPI/core access, collisions, lock, sequenced clear and reset.
module tb_spi_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  spi_addr;
  logic [7:0]  spi_wdata;
  logic        spi_wvld;
  logic [7:0]  spi_rdata;
  logic [5:0]  fastcmd;
  logic        fastcmd_vld;
  logic [7:0]  status;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_addr;
  logic [7:0]  core_wdata;
  logic        core_gnt;
  logic [7:0]  core_rdata;
  logic        core_rvld;
  logic [63:0] reg_q;

  int n_checks = 0;
  int n_err    = 0;

  spi_reg_arbiter #(.ADDR_W(3), .REG_W(8)) dut (
    .clk(clk), .rst(rst),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wvld(spi_wvld), .spi_rdata(spi_rdata),
    .fastcmd(fastcmd), .fastcmd_vld(fastcmd_vld), .status(status),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvld(core_rvld),
    .reg_q(reg_q)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; spi_addr = '0; spi_wdata = '0; spi_wvld = 1'b0;
    fastcmd = '0; fastcmd_vld = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    step(); step();
    chk("rst_status", status, 8'h00);
    chk("rst_regq", reg_q, 64'h0);
    chk("rst_gnt", core_gnt, 1'b0);
    chk("rst_spi_rdata", spi_rdata, 8'h00);
    rst = 1'b0;

    // 1: SPI write, 1-cycle read latency
    spi_addr = 3'd3; spi_wdata = 8'hA5; spi_wvld = 1'b1;
    step();
    spi_wvld = 1'b0;
    chk("t1_rdata_lat", spi_rdata, 8'h00);
    step();
    chk("t1_rdata", spi_rdata, 8'hA5);
    chk("t1_regq3", reg_q[31:24], 8'hA5);

    // 2: core read, back-to-back grants 2 cycles apart
    core_req = 1'b1; core_we = 1'b0; core_addr = 3'd3;
    step();
    chk("t2_gnt0", core_gnt, 1'b1);
    chk("t2_rvld0", core_rvld, 1'b1);
    chk("t2_rdata", core_rdata, 8'hA5);
    step();
    chk("t2_gap", core_gnt, 1'b0);
    step();
    chk("t2_gnt1", core_gnt, 1'b1);
    chk("t2_rvld1", core_rvld, 1'b1);
    core_req = 1'b0;
    step();

    // 3: same-address collision, core wins last
    spi_addr = 3'd5; spi_wdata = 8'h11; spi_wvld = 1'b1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 3'd5; core_wdata = 8'h22;
    step();
    spi_wvld = 1'b0;
    chk("t3_gnt_delayed", core_gnt, 1'b0);
    chk("t3_spi_first", reg_q[47:40], 8'h11);
    step();
    core_req = 1'b0;
    chk("t3_gnt", core_gnt, 1'b1);
    chk("t3_rvld_wr", core_rvld, 1'b0);
    step();
    chk("t3_final", reg_q[47:40], 8'h22);

    // 4: lock, discarded core write, error clear
    fastcmd = 6'h01; fastcmd_vld = 1'b1;
    step();
    fastcmd_vld = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_addr = 3'd0; core_wdata = 8'h7E;
    step();
    core_req = 1'b0;
    chk("t4_gnt", core_gnt, 1'b1);
    step();
    chk("t4_status", status, 8'h60);
    chk("t4_reg0", reg_q[7:0], 8'h00);
    fastcmd = 6'h03; fastcmd_vld = 1'b1;
    step();
    fastcmd = 6'h02;
    step();
    fastcmd_vld = 1'b0;
    chk("t4_errclr", status, 8'h40);
    step();
    chk("t4_unlock", status, 8'h00);

    // 5: fill bank, sequenced clear with dropped SPI write and waiting core read
    for (int i = 0; i < 8; i++) begin
      spi_addr = 3'(i); spi_wdata = 8'(8'h10 + i); spi_wvld = 1'b1;
      step();
    end
    spi_wvld = 1'b0;
    chk("t5_fill", reg_q, 64'h1716151413121110);
    fastcmd = 6'h00; fastcmd_vld = 1'b1;
    step();
    fastcmd_vld = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      spi_wvld = 1'b0;
      if (k == 2) begin
        spi_addr = 3'd0; spi_wdata = 8'hFF; spi_wvld = 1'b1;
      end
      if (k == 3) begin
        core_req = 1'b1; core_we = 1'b0; core_addr = 3'd6;
      end
      step();
      chk($sformatf("t5_busy%0d", k), status[7], 1'b1);
      chk($sformatf("t5_nognt%0d", k), core_gnt, 1'b0);
    end
    spi_wvld = 1'b0;
    chk("t5_cleared", reg_q, 64'h0);
    step();
    core_req = 1'b0;
    chk("t5_status_drop", status, 8'h10);
    chk("t5_gnt_after", core_gnt, 1'b1);
    chk("t5_rvld_after", core_rvld, 1'b1);
    chk("t5_rdata", core_rdata, 8'h00);
    step();
    fastcmd = 6'h03; fastcmd_vld = 1'b1;
    step();
    fastcmd_vld = 1'b0;
    step();

    // 6: clear requested during ACK, then reset mid-clear
    spi_addr = 3'd4; spi_wdata = 8'h5A; spi_wvld = 1'b1;
    step();
    spi_wvld = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 3'd4;
    step();
    core_req = 1'b0;
    chk("t6_gnt", core_gnt, 1'b1);
    chk("t6_rdata", core_rdata, 8'h5A);
    fastcmd = 6'h00; fastcmd_vld = 1'b1;
    step();
    fastcmd_vld = 1'b0;
    chk("t6_gnt_end", core_gnt, 1'b0);
    step();
    chk("t6_status_pend", status, 8'h88);
    chk("t6_spi_rdata", spi_rdata, 8'h5A);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_status", status, 8'h00);
    chk("t6_rst_regq", reg_q, 64'h0);
    chk("t6_rst_spi_rdata", spi_rdata, 8'h00);
    chk("t6_rst_core_rdata", core_rdata, 8'h00);
    chk("t6_rst_gnt", core_gnt, 1'b0);
    chk("t6_rst_rvld", core_rvld, 1'b0);
    step();
    chk("t6_post_status", status, 8'h00);
    chk("t6_post_gnt", core_gnt, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
